alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 63, meaning the maximum number of WAIT cycles before an error response.
REQ-003 SHALL have port clk, input, 1, the single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst_b, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1, meaning a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1, meaning the block accepts a command this cycle.
REQ-007 SHALL have port cmd_op, input, op_e, meaning the requested operation.
REQ-008 SHALL have ports cmd_a and cmd_b, input, WIDTH each, meaning operands A and B.
REQ-009 SHALL have port opcode, output, op_e, meaning the opcode presented to the ALU.
REQ-010 SHALL have port ibus, output, WIDTH, meaning the operand bus into the ALU.
REQ-011 SHALL have port obus, input, WIDTH, meaning the ALU result bus.
REQ-012 SHALL have port fin, input, 1, meaning the ALU completion strobe.
REQ-013 SHALL have ports res_valid and res_err, output, 1 each, meaning a result is held and whether it is an error.
REQ-014 SHALL have port res_data, output, WIDTH, meaning the captured result.
REQ-015 SHALL have port res_ready, input, 1, meaning the consumer takes the result.

Function
REQ-016 SHALL implement states IDLE, ISSUE, OPA, OPB, WAIT, RESP.
REQ-017 SHALL drive cmd_ready=1 only in IDLE; accept a command on cmd_valid&&cmd_ready and latch cmd_op/cmd_a/cmd_b.
REQ-018 SHALL on accept of a valid opcode (ADD..DIV) transition IDLE->ISSUE.
REQ-019 SHALL on accept of NOP, RD1, RD2 or an undefined encoding (1100-1111) transition IDLE->RESP with res_err=1 and res_data=0, driving no ALU activity.
REQ-020 SHALL drive opcode = latched op in ISSUE, OPA and OPB, and opcode=NOP in all other states.
REQ-021 SHALL drive ibus=A in OPA and ibus=B in OPB, and ibus=0 in all other states.
REQ-022 SHALL sequence ISSUE->OPA->OPB->WAIT unconditionally, one cycle each, with the same order for all operations including MUL and DIV.
REQ-023 SHALL in WAIT increment a wait counter from 0 each cycle; on a cycle with fin=1, capture obus into res_data, set res_err=0, and go to RESP.
REQ-024 SHALL when the counter equals TIMEOUT with fin=0, go to RESP with res_err=1 and res_data=0; if fin=1 on that same cycle, fin SHALL win.
REQ-025 SHALL ignore fin in every state except WAIT.
REQ-026 SHALL hold res_valid=1 with stable res_data/res_err throughout RESP; on res_valid&&res_ready, go to IDLE; a new command SHALL NOT be accepted in the same cycle.
REQ-027 SHALL give minimum latency accept->res_valid of 5 cycles (accept edge, ISSUE, OPA, OPB, WAIT with fin in first WAIT cycle).
REQ-028 SHALL keep cmd_ready=0 in all states other than IDLE, so no command is lost or overlapped.

Reset
REQ-029 SHALL on rst_b=0, immediately and at any state including mid-operation, force IDLE, opcode=NOP, ibus=0, cmd_ready=1 (after release), res_valid=0, res_err=0, res_data=0, and counter=0.
REQ-030 SHALL discard any in-flight command without emitting a response.

Structure
REQ-031 SHALL take op_e (4-bit: NOP=0, RD1=1, RD2=2, ADD=3, SUB=4, SHR=5, SHL=6, AND=7, OR=8, NEG=9, MUL=10, DIV=11) from the shared package alu_pkg, shared with the ALU; the sequencer state enum SHALL also live in alu_pkg.
REQ-032 SHALL place the WAIT counter and timeout compare in one sub-module, seq_timer (inputs clk, rst_b, clr, en; output expired).

Verification
REQ-033 SHALL verify ADD with A=5, B=7, fin pulsed in the 1st WAIT cycle with obus=12 -> opcode=ADD for 3 cycles, ibus 0/5/7, res_valid on the 5th cycle with res_data=12 and res_err=0.
REQ-034 SHALL verify MUL with A=3, B=4, fin after 32 WAIT cycles with obus=12 -> res_data=12, res_err=0, cmd_ready=0 throughout.
REQ-035 SHALL verify DIV with fin never asserted -> after 63 WAIT cycles res_valid=1, res_err=1, res_data=0.
REQ-036 SHALL verify cmd_op=4'b1110 -> res_valid 1 cycle after accept, res_err=1, opcode stays NOP.
REQ-037 SHALL verify res_ready held 0 for 10 cycles -> res_data stable, cmd_ready=0; then res_ready=1 -> IDLE the next cycle.
REQ-038 SHALL verify rst_b pulsed low during OPB -> outputs reset asynchronously, no response, next command handled normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, sequencer states and an opcode
// classifier used by both the sequencer and the ALU it drives.
package alu_pkg;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        RD1 = 4'd1,
        RD2 = 4'd2,
        ADD = 4'd3,
        SUB = 4'd4,
        SHR = 4'd5,
        SHL = 4'd6,
        AND = 4'd7,
        OR  = 4'd8,
        NEG = 4'd9,
        MUL = 4'd10,
        DIV = 4'd11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        OPA,
        OPB,
        WAIT,
        RESP
    } seq_state_e;

    // True only for opcodes that need the ALU; NOP, RD1/RD2 and 12..15 are rejected.
    function automatic logic is_alu_op(op_e op);
        return (op >= ADD) && (op <= DIV);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, result and ALU-side signals of the sequencer, bundled.
// master = the surrounding system (command source, ALU, result sink); slave = the sequencer.
interface alu_sequencer_if #(parameter int WIDTH = 32) ();
    import alu_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    op_e              opcode;
    logic [WIDTH-1:0] ibus;
    logic [WIDTH-1:0] obus;
    logic             fin;

    logic             res_valid;
    logic             res_err;
    logic [WIDTH-1:0] res_data;
    logic             res_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, obus, fin, res_ready,
        input  cmd_ready, opcode, ibus, res_valid, res_err, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, obus, fin, res_ready,
        output cmd_ready, opcode, ibus, res_valid, res_err, res_data
    );

endinterface

// File: rtl/seq_timer.sv
// WAIT-state counter: cleared outside WAIT, counts while enabled, and flags
// the TIMEOUT-th consecutive enabled cycle as expired.
module seq_timer #(
    parameter int TIMEOUT = 63
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign expired = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one command at a time into a multi-cycle ALU: opcode, then A, then B,
// then waits for fin (bounded by TIMEOUT) and holds the result until taken.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 63
) (
    input  logic            clk,
    input  logic            rst_b,
    alu_sequencer_if.slave  bus
);

    seq_state_e       state, state_nx;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, res_data_q;
    logic             res_err_q;
    logic             accept, expired;

    assign accept = bus.cmd_valid && (state == IDLE);

    seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (state != WAIT),
        .en      (state == WAIT),
        .expired (expired)
    );

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nx      = state;
        bus.cmd_ready = 1'b0;
        bus.opcode    = NOP;
        bus.ibus      = '0;
        bus.res_valid = 1'b0;
        bus.res_err   = res_err_q;
        bus.res_data  = res_data_q;
        unique case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (accept) state_nx = is_alu_op(bus.cmd_op) ? ISSUE : RESP;
            end
            ISSUE: begin
                bus.opcode = op_q;
                state_nx   = OPA;
            end
            OPA: begin
                bus.opcode = op_q;
                bus.ibus   = a_q;
                state_nx   = OPB;
            end
            OPB: begin
                bus.opcode = op_q;
                bus.ibus   = b_q;
                state_nx   = WAIT;
            end
            WAIT: begin
                if (bus.fin || expired) state_nx = RESP;
            end
            RESP: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Result registers change only on entry to RESP, so they are stable while it is held.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            op_q       <= NOP;
            a_q        <= '0;
            b_q        <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= bus.cmd_op;
                a_q  <= bus.cmd_a;
                b_q  <= bus.cmd_b;
                if (!is_alu_op(bus.cmd_op)) begin
                    res_data_q <= '0;
                    res_err_q  <= 1'b1;
                end
            end
            if (state == WAIT) begin
                if (bus.fin) begin
                    res_data_q <= bus.obus;
                    res_err_q  <= 1'b0;
                end else if (expired) begin
                    res_data_q <= '0;
                    res_err_q  <= 1'b1;
                end
            end
        end
    end

endmodule
